stream_source: RTL
==================

# stream_source

Valid/ready traffic transmitter that drives the upstream side of a node chain. It accepts a one-shot command (start value, beat count, step) and emits an arithmetic data sequence on a valid/ready output. Data is held stable under downstream backpressure, and completion is signalled with a one-cycle pulse. It is the standard stimulus/producer end for the handshake pipeline nodes.

## Interface
- WIDTH, 32, data and step width
- CNT_W, 16, beat-count width; max burst 2^CNT_W-1 beats
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid_in  in  1  command offered
- cmd_ready_out  out  1  command accepted when high with cmd_valid_in
- cmd_start_in  in  WIDTH  first data value
- cmd_step_in  in  WIDTH  increment between beats
- cmd_count_in  in  CNT_W  number of beats, 0 allowed
- data_out  out  WIDTH  beat data to downstream node
- dn_valid_out  out  1  beat valid to downstream node
- dn_ready_in  in  1  ready from downstream node
- last_out  out  1  high with the final beat of a burst
- busy_out  out  1  high from command accept until done pulse ends
- done_out  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, RUN, DONE. The state enum lives in the package.
- cmd_fire = cmd_valid_in & cmd_ready_out. dn_fire = dn_valid_out & dn_ready_in.
- cmd_ready_out = (state == IDLE). It is combinational from state only and never depends on dn_ready_in.
- IDLE + cmd_fire with count>0: go to RUN. Latch data_out=start, step, and remaining=count.
- IDLE + cmd_fire with count=0: go to DONE. No beat is emitted.
- RUN: dn_valid_out=1.
  - On a dn_fire with remaining>1: data_out += step (mod 2^WIDTH, wrap-around silent), remaining -= 1.
  - On a dn_fire with remaining==1: go to DONE and drop dn_valid_out.
- last_out = RUN & (remaining == 1).
- DONE: done_out=1 for exactly one cycle, then go to IDLE.
- busy_out = (state != IDLE).
- Valid/ready rules:
  - Once dn_valid_out rises, it stays high and data_out/last_out stay unchanged until dn_fire.
  - The block never withdraws valid.
  - The block does not look at dn_ready_in before asserting valid.
- Command inputs are ignored outside IDLE.

## Timing
- Reset values: dn_valid_out=0, data_out=0, last_out=0, cmd_ready_out=1 (state IDLE), busy_out=0, done_out=0. remaining=0.
- Reset asserted mid-burst: outputs return to reset values immediately, and the in-flight beat is dropped. After reset release, the first edge sees IDLE.
- Cycle after cmd_fire: first beat valid (count>0), or done_out=1 (count=0).
- With dn_ready_in held high: one beat per cycle, and N beats occupy N consecutive cycles.
- Cycle after the last dn_fire: done_out=1. The cycle after that: cmd_ready_out=1.
- Minimum command-to-command spacing: N+2 cycles for N>0, 2 cycles for N=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from dn_ready_in or cmd_valid_in to any output.

## Structure
- Package stream_pkg holds:
  - the state enum (IDLE, RUN, DONE, 2-bit)
  - localparams for default WIDTH and CNT_W, shared with the pipeline node benches.
- Single module, no sub-module. Datapath is one WIDTH adder, one CNT_W down-counter, and the state register.

## Test plan
- Basic burst: start=10, step=3, count=4, dn_ready_in=1 → data 10,13,16,19 on consecutive cycles. last_out only with 19. done_out one cycle after the beat 19 fires.
- Backpressure: same command with dn_ready_in toggling 1,0,0,1,0,1,1 → each value is held while ready=0. Sequence is 10,13,16,19 with no duplicates or skips, and valid never drops mid-burst.
- Zero count: count=0 → no dn_valid_out. done_out=1 the cycle after accept. cmd_ready_out=1 the cycle after that.
- Wrap-around: WIDTH=8, start=8'hFE, step=1, count=4 → FE, FF, 00, 01.
- Command ignored while busy: second cmd_valid_in during RUN → cmd_ready_out=0. The burst is unaffected, and the second command is accepted only after done_out.
- Reset mid-burst: assert rst after 2 of 5 beats → dn_valid_out=0 and done_out=0 immediately. A new command after release starts cleanly from its own start value.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream source and the handshake pipeline node benches.
package stream_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stream_source.sv
// Valid/ready producer: emits start, start+step, ... for a one-shot command,
// holds each beat under backpressure and pulses done_out once the burst is finished.
module stream_source
    import stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [WIDTH-1:0] cmd_start_in,
    input  logic [WIDTH-1:0] cmd_step_in,
    input  logic [CNT_W-1:0] cmd_count_in,
    output logic [WIDTH-1:0] data_out,
    output logic             dn_valid_out,
    input  logic             dn_ready_in,
    output logic             last_out,
    output logic             busy_out,
    output logic             done_out
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] step;
    logic [CNT_W-1:0] remaining;
    logic             cmd_fire;
    logic             dn_fire;
    logic             final_beat;

    assign cmd_fire   = cmd_valid_in & cmd_ready_out;
    assign dn_fire    = dn_valid_out & dn_ready_in;
    assign final_beat = (remaining == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nx = (cmd_count_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (dn_fire && final_beat) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Every output decodes registered state only, so nothing is combinational from the inputs.
    always_comb begin
        cmd_ready_out = 1'b0;
        dn_valid_out  = 1'b0;
        last_out      = 1'b0;
        done_out      = 1'b0;
        busy_out      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready_out = 1'b1;
                busy_out      = 1'b0;
            end
            RUN: begin
                dn_valid_out = 1'b1;
                last_out     = final_beat;
            end
            DONE: begin
                done_out = 1'b1;
            end
            default: begin
                busy_out = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            step      <= '0;
            remaining <= '0;
        end else if (cmd_fire) begin
            data_out  <= cmd_start_in;
            step      <= cmd_step_in;
            remaining <= cmd_count_in;
        end else if (dn_fire) begin
            remaining <= remaining - CNT_W'(1);
            // The final beat stays on data_out; only intermediate beats advance.
            if (!final_beat) begin
                data_out <= data_out + step;
            end
        end
    end

endmodule
